// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants, state and instruction-class types for the mc_ctrl FSM
package mc_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_JR      = 6'b001000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_NONE, CL_ADDU, CL_SUBU, CL_JR, CL_ORI, CL_LUI,
        CL_LW, CL_SW, CL_BEQ, CL_JAL, CL_ILLEGAL
    } instr_class_e;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] RD_RT     = 2'd0;
    localparam logic [1:0] RD_RD     = 2'd1;
    localparam logic [1:0] RD_RA     = 2'd2;

    localparam logic [1:0] MR_ALUOUT = 2'd0;
    localparam logic [1:0] MR_MDR    = 2'd1;
    localparam logic [1:0] MR_PC     = 2'd2;
    localparam logic [1:0] MR_LUI    = 2'd3;

    localparam logic [1:0] B_RT      = 2'd0;
    localparam logic [1:0] B_FOUR    = 2'd1;
    localparam logic [1:0] B_IMM     = 2'd2;
    localparam logic [1:0] B_IMM_SH2 = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_OR    = 2'd2;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_LUI   = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational opcode/funct to instruction-class mapping
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e cls
);

    always_comb begin
        cls = CL_ILLEGAL;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU: cls = CL_ADDU;
                    FN_SUBU: cls = CL_SUBU;
                    FN_JR:   cls = CL_JR;
                    default: cls = CL_ILLEGAL;
                endcase
            end
            OP_ORI:  cls = CL_ORI;
            OP_LUI:  cls = CL_LUI;
            OP_LW:   cls = CL_LW;
            OP_SW:   cls = CL_SW;
            OP_BEQ:  cls = CL_BEQ;
            OP_JAL:  cls = CL_JAL;
            default: cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-lite controller with wait-stated memory
// Optional MC_CTRL_PERF_EN adds perf_cycles / perf_instr counters.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0,
    parameter int WAIT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  regdst,
    output logic [1:0]  memtoreg,
    output logic        alusrc_a,
    output logic [1:0]  alusrc_b,
    output logic [1:0]  aluctrl,
    output logic [1:0]  extop,
    output logic        illegal,
    output logic        mem_err,
`ifdef MC_CTRL_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_instr,
`endif
    output logic [2:0]  state
);

    state_e            state_q, state_d;
    instr_class_e      cls_q, cls_d, dec_cls;
    logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
    logic              wait_hit;
    logic              unused_instr;

    assign unused_instr = ^instr[25:6];

    mc_decode u_decode (
        .opcode (instr[31:26]),
        .funct  (instr[5:0]),
        .cls    (dec_cls)
    );

    // wait_q counts unready cycles already spent; this cycle would be number wait_q+1
    assign wait_inc = (&wait_q) ? wait_q : wait_q + WAIT_W'(1);
    assign wait_hit = (MEM_WAIT_MAX != 0) && ((32'(wait_q) + 32'd1) >= 32'(MEM_WAIT_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cls_q   <= CL_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = (state_q == S_DECODE) ? dec_cls : cls_q;
        wait_d    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_ALU;
        reg_write = 1'b0;
        regdst    = RD_RT;
        memtoreg  = MR_ALUOUT;
        alusrc_a  = 1'b0;
        alusrc_b  = B_RT;
        aluctrl   = ALU_ADD;
        extop     = EXT_ZERO;
        illegal   = 1'b0;
        mem_err   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                alusrc_b = B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_hit) begin
                    mem_err  = 1'b1;
                end else begin
                    wait_d   = wait_inc;
                end
            end
            S_DECODE: begin
                alusrc_b = B_IMM_SH2;
                extop    = EXT_SIGN;
                if (dec_cls == CL_JAL) begin
                    state_d = S_WB;
                end else if (dec_cls == CL_ILLEGAL) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (cls_q)
                    CL_ADDU, CL_SUBU: begin
                        alusrc_a = 1'b1;
                        aluctrl  = (cls_q == CL_SUBU) ? ALU_SUB : ALU_ADD;
                        state_d  = S_WB;
                    end
                    CL_ORI: begin
                        alusrc_a = 1'b1;
                        alusrc_b = B_IMM;
                        aluctrl  = ALU_OR;
                        state_d  = S_WB;
                    end
                    CL_LUI: begin
                        extop    = EXT_LUI;
                        state_d  = S_WB;
                    end
                    CL_LW, CL_SW: begin
                        alusrc_a = 1'b1;
                        alusrc_b = B_IMM;
                        extop    = EXT_SIGN;
                        state_d  = S_MEM;
                    end
                    CL_BEQ: begin
                        alusrc_a = 1'b1;
                        aluctrl  = ALU_SUB;
                        pc_src   = PC_ALUOUT;
                        pc_write = zero;
                    end
                    CL_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_RS;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (cls_q == CL_LW);
                mem_write = (cls_q == CL_SW);
                if (mem_ready) begin
                    state_d = (cls_q == CL_LW) ? S_WB : S_FETCH;
                end else if (wait_hit) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    wait_d  = wait_inc;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                case (cls_q)
                    CL_ADDU, CL_SUBU: regdst = RD_RD;
                    CL_LUI:           memtoreg = MR_LUI;
                    CL_LW:            memtoreg = MR_MDR;
                    CL_JAL: begin
                        regdst   = RD_RA;
                        memtoreg = MR_PC;
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                    default: regdst = RD_RT;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state = state_q;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_instr_q;
    logic        instr_done;

    // timeouts and illegal opcodes never reach these exits with work retired
    assign instr_done = (state_q == S_WB)
                     || (state_q == S_EXEC && state_d == S_FETCH)
                     || (state_q == S_MEM && mem_ready && cls_q == CL_SW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles_q <= '0;
            perf_instr_q  <= '0;
        end else begin
            if (state_q != S_IDLE) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (instr_done)        perf_instr_q  <= perf_instr_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_instr  = perf_instr_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a per-instruction sequence model
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [1:0] aluctrl;
        logic [1:0] extop;
        logic       illegal;
        logic       mem_err;
    } ov_t;

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_ILL} kind_e;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero, mem_ready;
    logic        mem_read, mem_write, iord, ir_write, pc_write, reg_write;
    logic        alusrc_a, illegal, mem_err;
    logic [1:0]  pc_src, regdst, memtoreg, alusrc_b, aluctrl, extop;
    logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_instr;
`endif
    logic [23:0] got_v;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_WAIT_MAX(4), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .regdst(regdst),
        .memtoreg(memtoreg), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b), .aluctrl(aluctrl),
        .extop(extop), .illegal(illegal), .mem_err(mem_err),
`ifdef MC_CTRL_PERF_EN
        .perf_cycles(perf_cycles), .perf_instr(perf_instr),
`endif
        .state(state)
    );

    assign got_v = {state, mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg_write,
                    regdst, memtoreg, alusrc_a, alusrc_b, aluctrl, extop, illegal, mem_err};

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ov_t blank(input logic [2:0] s);
        ov_t e;
        e = '0;
        e.st = s;
        return e;
    endfunction

    function automatic kind_e kind_of(input logic [31:0] ins);
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h21:   return K_ADDU;
                    6'h23:   return K_SUBU;
                    6'h08:   return K_JR;
                    default: return K_ILL;
                endcase
            end
            6'h0D:   return K_ORI;
            6'h0F:   return K_LUI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h03:   return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] gen(input int k);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  op, fn;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        case (k)
            K_ADDU: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            K_SUBU: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            K_JR:   return {6'h00, rs, 15'd0, 6'h08};
            K_ORI:  return {6'h0D, rs, rt, imm};
            K_LUI:  return {6'h0F, 5'd0, rt, imm};
            K_LW:   return {6'h23, rs, rt, imm};
            K_SW:   return {6'h2B, rs, rt, imm};
            K_BEQ:  return {6'h04, rs, rt, imm};
            K_JAL:  return {6'h03, 26'($urandom)};
            default: begin
                if ($urandom_range(0, 1) == 1) begin
                    op = 6'($urandom);
                    while (op inside {6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h03}) op = 6'($urandom);
                    return {op, 26'($urandom)};
                end
                fn = 6'($urandom);
                while (fn inside {6'h21, 6'h23, 6'h08}) fn = 6'($urandom);
                return {6'h00, 20'($urandom), fn};
            end
        endcase
    endfunction

    // one cycle: drive mem_ready, sample just after the falling edge, advance to next falling edge
    task automatic step(input ov_t e, input logic mr, input string tag);
        mem_ready = mr;
        #1;
        check(tag, got_v, e);
        @(negedge clk);
    endtask

    // walks one instruction from FETCH; every 4th consecutive unready cycle is a timeout
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z, input int mabort);
        kind_e k;
        ov_t   e;
        int    cnt;
        k     = kind_of(ins);
        instr = ins;
        zero  = z;
        cnt   = 0;
        for (int i = 0; i < fw; i++) begin
            e = blank(3'd1); e.mem_read = 1'b1; e.alusrc_b = 2'd1;
            if (cnt == 3) begin e.mem_err = 1'b1; cnt = 0; end else cnt++;
            step(e, 1'b0, "fetch_wait");
        end
        e = blank(3'd1); e.mem_read = 1'b1; e.alusrc_b = 2'd1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        step(e, 1'b1, "fetch_ready");
        e = blank(3'd2); e.alusrc_b = 2'd3; e.extop = 2'd1; e.illegal = (k == K_ILL);
        step(e, 1'($urandom), "decode");
        if (k == K_ILL) return;
        if (k != K_JAL) begin
            e = blank(3'd3);
            case (k)
                K_ADDU: e.alusrc_a = 1'b1;
                K_SUBU: begin e.alusrc_a = 1'b1; e.aluctrl = 2'd1; end
                K_ORI:  begin e.alusrc_a = 1'b1; e.alusrc_b = 2'd2; e.aluctrl = 2'd2; end
                K_LUI:  e.extop = 2'd2;
                K_LW, K_SW: begin e.alusrc_a = 1'b1; e.alusrc_b = 2'd2; e.extop = 2'd1; end
                K_BEQ:  begin e.alusrc_a = 1'b1; e.aluctrl = 2'd1; e.pc_src = 2'd1; e.pc_write = z; end
                K_JR:   begin e.pc_write = 1'b1; e.pc_src = 2'd3; end
                default: ;
            endcase
            step(e, 1'($urandom), "exec");
            if (k == K_BEQ || k == K_JR) return;
            if (k == K_LW || k == K_SW) begin
                cnt = 0;
                for (int i = 0; i < mw; i++) begin
                    if (i == mabort) return;
                    e = blank(3'd4); e.iord = 1'b1; e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
                    if (cnt == 3) begin
                        e.mem_err = 1'b1;
                        step(e, 1'b0, "mem_timeout");
                        return;
                    end
                    cnt++;
                    step(e, 1'b0, "mem_wait");
                end
                e = blank(3'd4); e.iord = 1'b1; e.mem_read = (k == K_LW); e.mem_write = (k == K_SW);
                step(e, 1'b1, "mem_ready");
                if (k == K_SW) return;
            end
        end
        e = blank(3'd5); e.reg_write = 1'b1;
        case (k)
            K_ADDU, K_SUBU: e.regdst = 2'd1;
            K_LUI:  e.memtoreg = 2'd3;
            K_LW:   e.memtoreg = 2'd1;
            K_JAL:  begin e.regdst = 2'd2; e.memtoreg = 2'd2; e.pc_write = 1'b1; e.pc_src = 2'd2; end
            default: ;
        endcase
        step(e, 1'($urandom), "wb");
    endtask

    initial begin
        int k, fw, mw;
        reset = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset", got_v, blank(3'd0));
        reset = 1'b1;
        #1 check("idle_release", got_v, blank(3'd0));
        @(negedge clk);

        run_instr(32'h00221821, 0, 0, 1'b0, -1);   // addu $3,$1,$2
        run_instr(32'h8C220004, 0, 3, 1'b0, -1);   // lw, 3 wait cycles in MEM
        run_instr(32'h10220003, 0, 0, 1'b1, -1);   // beq taken
        run_instr(32'h10220003, 0, 0, 1'b0, -1);   // beq not taken
        run_instr(32'h0C000010, 0, 0, 1'b0, -1);   // jal
        run_instr(32'h03E00008, 0, 0, 1'b0, -1);   // jr $31
        run_instr(32'h34220005, 4, 0, 1'b0, -1);   // ori after fetch timeout
        run_instr(32'hFC000000, 0, 0, 1'b0, -1);   // opcode 111111
        run_instr(32'h00000000, 0, 0, 1'b0, -1);   // special, bad funct
        run_instr(32'h3C021234, 2, 0, 1'b0, -1);   // lui
        run_instr(32'hAC220004, 1, 2, 1'b0, -1);   // sw
        run_instr(32'h8C220004, 0, 4, 1'b0, -1);   // lw MEM timeout

        run_instr(32'h8C220004, 0, 5, 1'b0, 1);    // stop inside MEM, then reset
        #2 reset = 1'b0;
        #1 check("reset_mid_mem", got_v, blank(3'd0));
        @(negedge clk);
        reset = 1'b1;
        #1 check("idle_release2", got_v, blank(3'd0));
        @(negedge clk);

        for (int n = 0; n < 250; n++) begin
            k  = $urandom_range(0, 9);
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 9) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            run_instr(gen(k), fw, mw, 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
